spi_master_param: RTL and testbench

//  Parametrised full-duplex SPI master: width, SCLK divider, CPOL/CPHA mode, bit order.

---
 rtl/spi_master_param.sv | 136 +++++++++++++
 tb/tb_spi_master_param.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_param.sv
// Full-duplex SPI master: one frame per tx_valid/tx_ready handshake, CS low one cycle after accept.
// rx_valid pulses as CS rises; tx_ready stays low from accept until the CS gap has elapsed.
module spi_master_param #(
   parameter int DATA_WIDTH = 8,
   parameter int CLK_DIV    = 2,
   parameter bit CPOL       = 1'b0,
   parameter bit CPHA       = 1'b0,
   parameter bit LSB_FIRST  = 1'b1,
   parameter int CS_GAP     = 2
) (
   input  logic                  SPI_module_clk,
   input  logic                  SPI_rst_n,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  busy,
   output logic                  SPI_CLK,
   output logic                  SPI_TX,
   input  logic                  SPI_RX,
   output logic                  SPI_CS
);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
   localparam int EW = $clog2(2 * DATA_WIDTH + 1);
   localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'(CS_GAP - 1);
   localparam logic [EW-1:0] EDGE_LAST  = EW'(2 * DATA_WIDTH);
   localparam logic [EW-1:0] SHIFT_LAST = EW'(2 * DATA_WIDTH - 2);

   typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, GAP} state_t;

   state_t                state;
   logic [DW-1:0]         div_cnt;
   logic [GW-1:0]         gap_cnt;
   logic [EW-1:0]         edge_cnt;
   logic [EW-1:0]         edge_nxt;
   logic [DATA_WIDTH-1:0] tx_sh;
   logic [DATA_WIDTH-1:0] rx_sh;
   logic                  accept;
   logic                  div_done;
   logic                  lead_edge;

   function automatic logic first_bit(input logic [DATA_WIDTH-1:0] v);
      return LSB_FIRST ? v[0] : v[DATA_WIDTH-1];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] v);
      return LSB_FIRST ? (v >> 1) : (v << 1);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] v, input logic b);
      return LSB_FIRST ? {b, v[DATA_WIDTH-1:1]} : {v[DATA_WIDTH-2:0], b};
   endfunction

   assign accept    = tx_valid & tx_ready & (state == IDLE);
   assign div_done  = (div_cnt == DIV_LAST);
   assign edge_nxt  = edge_cnt + EW'(1);
   assign lead_edge = ~edge_cnt[0];

   always_ff @(posedge SPI_module_clk) begin
      if (!SPI_rst_n) begin
         state    <= IDLE;
         div_cnt  <= '0;
         gap_cnt  <= '0;
         edge_cnt <= '0;
         tx_sh    <= '0;
         rx_sh    <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         tx_ready <= 1'b0;
         busy     <= 1'b0;
         SPI_CS   <= 1'b1;
         SPI_CLK  <= CPOL;
         SPI_TX   <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         case (state)
            IDLE: begin
               tx_ready <= 1'b1;
               if (accept) begin
                  state    <= LEAD;
                  tx_ready <= 1'b0;
                  busy     <= 1'b1;
                  SPI_CS   <= 1'b0;
                  div_cnt  <= '0;
                  edge_cnt <= '0;
                  // CPHA=0 must present the first bit before the first (sampling) edge
                  if (CPHA) begin
                     tx_sh  <= tx_data;
                     SPI_TX <= 1'b0;
                  end else begin
                     tx_sh  <= shift_out(tx_data);
                     SPI_TX <= first_bit(tx_data);
                  end
               end
            end
            LEAD, XFER: begin
               div_cnt <= div_done ? '0 : div_cnt + DW'(1);
               if (div_done) begin
                  edge_cnt <= edge_nxt;
                  SPI_CLK  <= ~SPI_CLK;
                  if (lead_edge != CPHA)
                     rx_sh <= shift_in(rx_sh, SPI_RX);
                  if ((lead_edge == CPHA) && (CPHA || (edge_nxt <= SHIFT_LAST))) begin
                     SPI_TX <= first_bit(tx_sh);
                     tx_sh  <= shift_out(tx_sh);
                  end
                  state <= (edge_nxt == EDGE_LAST) ? TRAIL : XFER;
               end
            end
            TRAIL: begin
               div_cnt <= div_done ? '0 : div_cnt + DW'(1);
               if (div_done) begin
                  state    <= GAP;
                  SPI_CS   <= 1'b1;
                  SPI_TX   <= 1'b0;
                  rx_valid <= 1'b1;
                  rx_data  <= rx_sh;
                  gap_cnt  <= '0;
               end
            end
            GAP: begin
               gap_cnt <= gap_cnt + GW'(1);
               if (gap_cnt == GAP_LAST) begin
                  state    <= IDLE;
                  tx_ready <= 1'b1;
                  busy     <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_master_param.sv
// Six parameterisations of spi_master_param, each compared every cycle with a frame-timeline model
// and against hand-computed per-frame values (received word, MOSI word, edge count, CS timing).
module tb_spi_master_param;
   localparam int NCFG   = 6;
   localparam int NFR    = 3;
   localparam int CS_GAP = 2;

   localparam int P_W     [NCFG] = '{8, 8, 8, 8, 16, 2};
   localparam int P_DIV   [NCFG] = '{2, 2, 2, 2, 4, 1};
   localparam bit P_CPOL  [NCFG] = '{0, 0, 1, 1, 0, 0};
   localparam bit P_CPHA  [NCFG] = '{0, 1, 0, 1, 0, 0};
   localparam bit P_LSB   [NCFG] = '{1, 1, 1, 1, 0, 1};
   localparam int P_CSLOW [NCFG] = '{34, 34, 34, 34, 132, 5};
   localparam bit P_B2B   [NCFG] = '{1, 0, 0, 0, 0, 0};
   localparam bit P_ABORT [NCFG] = '{0, 0, 0, 1, 0, 0};

   localparam logic [15:0] P_TX [NCFG*NFR] = '{
      16'h00A5, 16'h0081, 16'h005A,   16'h0081, 16'h000F, 16'h00C3,
      16'h0081, 16'h0055, 16'h007E,   16'h0081, 16'h0012, 16'h00E7,
      16'h8001, 16'h1234, 16'hF00F,   16'h0002, 16'h0001, 16'h0003};
   localparam logic [15:0] P_SLV [NCFG*NFR] = '{
      16'h003C, 16'h0000, 16'h0000,   16'h0000, 16'h0096, 16'h0000,
      16'h0000, 16'h00AA, 16'h0000,   16'h0000, 16'h0034, 16'h0000,
      16'h0000, 16'hBEEF, 16'h0000,   16'h0000, 16'h0003, 16'h0001};
   localparam bit P_LOOP [NCFG*NFR] = '{0, 1, 1,  1, 0, 1,  1, 0, 1,  1, 0, 1,  1, 0, 1,  1, 0, 0};
   localparam logic [15:0] P_EXP [NCFG*NFR] = '{
      16'h003C, 16'h0081, 16'h005A,   16'h0081, 16'h0096, 16'h00C3,
      16'h0081, 16'h00AA, 16'h007E,   16'h0081, 16'h0034, 16'h00E7,
      16'h8001, 16'hBEEF, 16'hF00F,   16'h0002, 16'h0003, 16'h0001};

   logic clk = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   n_done = 0;

   always #5 clk = ~clk;

   task automatic chk(input int cfg, input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL cfg%0d %s: got %0h want %0h", cfg, name, act, exp);
      end
   endtask

   for (genvar g = 0; g < NCFG; g++) begin : cfg
      localparam int W   = P_W[g];
      localparam int DIV = P_DIV[g];
      localparam bit POL = P_CPOL[g];
      localparam bit PHA = P_CPHA[g];
      localparam bit LSB = P_LSB[g];
      localparam int ACT = (2 * W + 1) * DIV;
      localparam int LAST = ACT + CS_GAP;

      logic         rst_n, tx_valid, tx_ready, rx_valid, busy, sclk, mosi, miso, cs;
      logic [W-1:0] tx_data, rx_data, slv_frame;
      logic         loop = 1'b0;
      logic         slv_bit = 1'b0;

      spi_master_param #(.DATA_WIDTH(W), .CLK_DIV(DIV), .CPOL(POL), .CPHA(PHA),
                         .LSB_FIRST(LSB), .CS_GAP(CS_GAP)) dut (
         .SPI_module_clk(clk), .SPI_rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
         .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
         .SPI_CLK(sclk), .SPI_TX(mosi), .SPI_RX(miso), .SPI_CS(cs));

      assign miso = loop ? mosi : slv_bit;

      // Model: d = cycles since the accepting edge; every output is a function of d.
      bit           m_on = 0, m_act = 0, m_rdy = 0;
      int           m_d = 0;
      logic [W-1:0] m_tx = '0, m_frame = '0, m_rx = '0;

      always @(posedge clk) begin
         if (!rst_n) begin
            m_on = 1; m_act = 0; m_rdy = 0; m_rx = '0;
         end else if (m_act) begin
            m_d = m_d + 1;
            if (m_d == ACT + 1) m_rx = m_frame;
            if (m_d > LAST) begin m_act = 0; m_rdy = 1; end
         end else if (m_rdy && tx_valid) begin
            m_act = 1; m_d = 1; m_rdy = 0; m_tx = tx_data;
            m_frame = loop ? tx_data : slv_frame;
         end else begin
            m_rdy = 1;
         end
      end

      always @(negedge clk) begin
         int   e, idx;
         bit   in_frame;
         logic xt;
         if (m_on) begin
            in_frame = m_act && (m_d <= ACT);
            e = 0;
            if (in_frame && m_d > DIV) e = (m_d - 1) / DIV;
            if (e > 2 * W) e = 2 * W;
            xt = 1'b0;
            if (in_frame) begin
               idx = PHA ? ((e == 0) ? -1 : (e + 1) / 2 - 1) : e / 2;
               if (idx > W - 1) idx = W - 1;
               if (idx >= 0) xt = LSB ? m_tx[idx] : m_tx[W-1-idx];
            end
            chk(g, "spi_cs", cs, !in_frame);
            chk(g, "spi_clk", sclk, POL ^ e[0]);
            chk(g, "spi_tx", mosi, xt);
            chk(g, "busy", busy, m_act);
            chk(g, "tx_ready", tx_ready, m_rdy);
            chk(g, "rx_valid", rx_valid, m_act && (m_d == ACT + 1));
            chk(g, "rx_data", rx_data, m_rx);
         end
      end

      // Slave side: reconstructs the MOSI word, counts edges/CS cycles, drives MISO.
      logic         p_clk = POL, p_cs = 1'b1;
      int           nrise = 0, nlow = 0, nhi = 0, nbits = 0, lead_n = 0, trail_n = 0, npulse = 0;
      int           s_rise = 0, s_low = 0, s_gap = 0, sidx;
      logic [W-1:0] got = '0, s_got = '0;

      always @(negedge clk) begin
         if (p_cs && !cs) begin
            s_gap = nhi; nhi = 0; nrise = 0; nlow = 0; nbits = 0; lead_n = 0; trail_n = 0; got = '0;
         end
         if (!cs) begin
            nlow++;
            if (sclk != p_clk) begin
               if (sclk) nrise++;
               if (p_clk == POL) lead_n++; else trail_n++;
               if (((p_clk == POL) != PHA) && nbits < W) begin
                  got[LSB ? nbits : W - 1 - nbits] = mosi;
                  nbits++;
               end
            end
         end else begin
            nhi++;
         end
         if (!p_cs && cs) begin s_rise = nrise; s_low = nlow; s_got = got; end
         if (rx_valid) npulse++;
         sidx = PHA ? lead_n - 1 : trail_n;
         slv_bit = (sidx < 0 || sidx >= W) ? 1'b0 : (LSB ? slv_frame[sidx] : slv_frame[W-1-sidx]);
         p_clk = sclk;
         p_cs  = cs;
      end

      task automatic accept_wait();
         bit ok = 0;
         for (int i = 0; i < 200; i++) begin
            if (tx_ready) begin ok = 1; break; end
            @(negedge clk);
         end
         chk(g, "accept_timeout", ok, 1);
         @(negedge clk);
      endtask

      initial begin
         bit ok;
         int k, lat;
         rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; slv_frame = '0;
         repeat (3) @(negedge clk);
         chk(g, "reset_ready_low", tx_ready, 0);
         chk(g, "reset_cs_high", cs, 1);
         rst_n = 1'b1;
         @(negedge clk);
         chk(g, "ready_after_release", tx_ready, 1);

         if (P_ABORT[g]) begin
            loop = 1'b1; tx_data = '1; tx_valid = 1'b1;
            accept_wait();
            tx_valid = 1'b0;
            repeat (9) @(negedge clk);
            chk(g, "abort_cs_low_before", cs, 0);
            rst_n = 1'b0;
            @(negedge clk);
            chk(g, "abort_cs", cs, 1);
            chk(g, "abort_sclk", sclk, POL);
            chk(g, "abort_mosi", mosi, 0);
            chk(g, "abort_rx_valid", rx_valid, 0);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            chk(g, "abort_ready", tx_ready, 1);
         end

         for (int f = 0; f < NFR; f++) begin
            k = g * NFR + f;
            loop = P_LOOP[k];
            slv_frame = W'(P_SLV[k]);
            if (!(P_B2B[g] && f == 2)) begin
               tx_data = W'(P_TX[k]);
               tx_valid = 1'b1;
            end
            accept_wait();
            if (P_B2B[g] && f == 1) tx_data = W'(P_TX[k+1]);
            else begin tx_valid = 1'b0; tx_data = ~tx_data; end
            ok = 0; lat = 0;
            for (int i = 0; i < 400; i++) begin
               @(negedge clk);
               if (rx_valid) begin ok = 1; lat = i + 2; break; end
            end
            chk(g, "rx_timeout", ok, 1);
            chk(g, "rx_latency", lat, P_CSLOW[g] + 1);
            chk(g, "rx_word", rx_data, W'(P_EXP[k]));
            @(negedge clk);
            chk(g, "sclk_rises", s_rise, W);
            chk(g, "cs_low_cycles", s_low, P_CSLOW[g]);
            chk(g, "mosi_word", s_got, W'(P_TX[k]));
            if (P_B2B[g] && f == 2) chk(g, "cs_gap", s_gap, CS_GAP + 1);
         end
         repeat (5) @(negedge clk);
         chk(g, "rx_pulses", npulse, NFR);
         n_done++;
      end
   end

   initial begin
      bit all_done = 0;
      for (int i = 0; i < 20000; i++) begin
         @(posedge clk);
         if (n_done == NCFG) begin all_done = 1; break; end
      end
      chk(-1, "all_configs_done", all_done, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
